// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit codes, unit type and default data width.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef logic [1:0] unit_t;

    localparam unit_t UNIT_ARITH = 2'd0;
    localparam unit_t UNIT_LOGIC = 2'd1;
    localparam unit_t UNIT_CMP   = 2'd2;
    localparam unit_t UNIT_SHIFT = 2'd3;

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with count-derived full/empty.
module alu_res_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Head reads as zero when empty so outputs have a defined reset value.
    assign dout = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects one-hot ALU unit results into a FIFO drained by valid/ready.
// Optional head parity check: define ALU_COLLECT_PARITY_EN.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       Arith_OUT,
    input  logic [WIDTH-1:0]       Logic_OUT,
    input  logic [WIDTH-1:0]       CMP_OUT,
    input  logic [WIDTH-1:0]       Shift_OUT,
    input  logic                   Carry_OUT,
    input  logic                   Arith_Flag,
    input  logic                   Logic_Flag,
    input  logic                   CMP_Flag,
    input  logic                   Shift_Flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_unit,
    output logic                   out_carry,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic                   empty,
    output logic [7:0]             drop_cnt,
    output logic                   err_multi
`ifdef ALU_COLLECT_PARITY_EN
    ,
    output logic                   out_parity_err
`endif
);

`ifdef ALU_COLLECT_PARITY_EN
    localparam int EW = WIDTH + 4;
`else
    localparam int EW = WIDTH + 3;
`endif

    logic [WIDTH-1:0] w_sel_data;
    unit_t            w_sel_unit;
    logic             w_sel_carry;
    logic             w_onehot;
    logic             w_multi;
    logic             w_pop;
    logic             w_drop;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic [7:0]       r_drop_cnt;
    logic             r_err_multi;

    always_comb begin
        w_sel_data = '0;
        w_sel_unit = UNIT_ARITH;
        w_onehot   = 1'b0;
        w_multi    = 1'b0;
        unique case ({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag})
            4'b0000: ;
            4'b0001: begin
                w_onehot   = 1'b1;
                w_sel_data = Arith_OUT;
                w_sel_unit = UNIT_ARITH;
            end
            4'b0010: begin
                w_onehot   = 1'b1;
                w_sel_data = Logic_OUT;
                w_sel_unit = UNIT_LOGIC;
            end
            4'b0100: begin
                w_onehot   = 1'b1;
                w_sel_data = CMP_OUT;
                w_sel_unit = UNIT_CMP;
            end
            4'b1000: begin
                w_onehot   = 1'b1;
                w_sel_data = Shift_OUT;
                w_sel_unit = UNIT_SHIFT;
            end
            default: w_multi = 1'b1;
        endcase
    end

    assign w_sel_carry = w_onehot && Arith_Flag && Carry_OUT;
    assign w_pop       = out_valid && out_ready;
    assign w_drop      = w_onehot && full && !w_pop;

`ifdef ALU_COLLECT_PARITY_EN
    assign w_entry = {^{w_sel_unit, w_sel_carry, w_sel_data},
                      w_sel_unit, w_sel_carry, w_sel_data};
`else
    assign w_entry = {w_sel_unit, w_sel_carry, w_sel_data};
`endif

    alu_res_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (w_onehot),
        .din   (w_entry),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign out_valid = !empty;
    assign out_data  = w_head[WIDTH-1:0];
    assign out_carry = w_head[WIDTH];
    assign out_unit  = w_head[WIDTH+2:WIDTH+1];

`ifdef ALU_COLLECT_PARITY_EN
    assign out_parity_err = out_valid &&
                            ((^w_head[WIDTH+2:0]) != w_head[WIDTH+3]);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_cnt  <= '0;
            r_err_multi <= 1'b0;
        end else begin
            if (w_multi) begin
                r_err_multi <= 1'b1;
            end
            if ((w_multi || w_drop) && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign err_multi = r_err_multi;

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the 16-bit ALU top level. Each cycle it takes the four registered unit results (arithmetic, logic, compare, shift) and their per-unit valid flags. When exactly one flag is high, it keeps the active result, tags it with the producing unit, and stores it in a small synchronous FIFO. The FIFO is drained through a valid/ready handshake toward writeback/register-file logic. Drops and protocol errors are reported.

## Interface
- `WIDTH`, 16, data width; matches the ALU operand/result width.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Arith_OUT`, `Logic_OUT`, `CMP_OUT`, `Shift_OUT`  in  WIDTH each  ALU unit results.
- `Carry_OUT`  in  1  arithmetic carry; meaningful only with `Arith_Flag`.
- `Arith_Flag`, `Logic_Flag`, `CMP_Flag`, `Shift_Flag`  in  1 each  per-unit result valid.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  WIDTH  head result.
- `out_unit`  out  2  head source: 0 arith, 1 logic, 2 cmp, 3 shift.
- `out_carry`  out  1  head carry; 0 for non-arith entries.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`, `empty`  out  1 each  occupancy status.
- `drop_cnt`  out  8  saturating count of lost results.
- `err_multi`  out  1  sticky; set when more than one flag is seen in the same cycle.

## Operation
- Capture condition: the flags are exactly one-hot. The selected result, unit code and carry (carry forced to 0 unless arith) form one entry.
- Zero flags: no action.
- Two or more flags:
  - no push;
  - `err_multi` set to 1 and held until `RST`;
  - `drop_cnt` incremented.
- Pop: `out_valid && out_ready` at a rising edge removes the head.
- Push acceptance: push is accepted when `!full`, or when `full` and a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- Drop: a capture while `full` with no pop in that cycle is discarded.
  - `drop_cnt` increments; FIFO contents are unchanged.
- `drop_cnt` saturates at 255; there is no wrap.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty are derived from `fifo_count`.
- `out_data`, `out_unit` and `out_carry` are driven from the head entry and are held stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid`=0, `fifo_count`=0, `empty`=1, `full`=0;
  - `drop_cnt`=0, `err_multi`=0;
  - `out_data`=0, `out_unit`=0, `out_carry`=0;
  - pointers 0.
- Reset during operation: all queued entries are discarded at that edge. Inputs present on the reset edge are ignored.

## Timing
- Push latency: a flag sampled high at edge N gives `out_valid`=1 after edge N when the FIFO was empty. That is one cycle from flag to head visibility.
- No combinational path from flag inputs to `out_valid`/`out_data`. All outputs are registered or decoded from registered state.
- Combinational `out_ready` → internal pop only. `out_ready` never affects `out_valid` in the same cycle.
- Throughput: one push and one pop per cycle, sustained.
- `fifo_count`, `full`, `empty` and `drop_cnt` update on the same edge as the event that changes them.

## Configuration
- Macro `ALU_COLLECT_PARITY_EN`.
- Defined:
  - each entry stores an even-parity bit over {unit, carry, data}, computed at push;
  - an extra output `out_parity_err` (1 bit) is asserted combinationally while `out_valid` and the recomputed head parity mismatches the stored bit;
  - reset value 0.
- Undefined: no parity storage and no `out_parity_err` port.

## Structure
- Shared package `alu_pkg` holds:
  - unit codes `UNIT_ARITH`=0, `UNIT_LOGIC`=1, `UNIT_CMP`=2, `UNIT_SHIFT`=3;
  - the 2-bit unit typedef;
  - the default data width constant (16).
- Sub-module `alu_res_fifo`: generic synchronous FIFO (parameters WIDTH, DEPTH) with push/pop/full/empty/count.
  - The collector wraps it with the one-hot select, the drop/error logic and the counters.

## Test plan
- Single capture:
  - after reset, `Arith_Flag`=1, `Arith_OUT`=16'hFFFE, `Carry_OUT`=1 for one cycle, `out_ready`=1;
  - next cycle `out_valid`=1, `out_data`=16'hFFFE, `out_unit`=0, `out_carry`=1, then `empty` returns to 1.
- Fill and drop:
  - `out_ready`=0, six consecutive `Logic_Flag` pulses with data 1..6;
  - `full`=1 after four pushes, `drop_cnt`=2;
  - draining yields 1,2,3,4 with `out_unit`=1.
- Full plus simultaneous push/pop:
  - FIFO full, `out_ready`=1 and `Shift_Flag`=1 with 16'h00AA in the same cycle;
  - `fifo_count` stays 4, and 16'h00AA appears last on drain.
- Multi-flag error:
  - `CMP_Flag`=`Shift_Flag`=1 in the same cycle;
  - no push, `err_multi`=1 persists, `drop_cnt`+1.
- Reset during operation:
  - three entries queued, `RST`=1 for one cycle;
  - next cycle `out_valid`=0, `fifo_count`=0, `drop_cnt`=0, `err_multi`=0.
